// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states, latched request.
// Latency: n/a (types only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_MERGE,
        ST_WR_ISSUE,
        ST_RESP
    } lsu_state_e;

    // Only the low half of the store data is kept: word stores go straight out at accept.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } lsu_req_t;

    function automatic logic is_fault(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] mem_bytes);
        logic bad_size;
        logic misaligned;
        bad_size   = (size == 2'b11);
        misaligned = ((size == SZ_HALF) && addr[0]) ||
                     ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        return bad_size || misaligned || (addr >= mem_bytes);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    always_comb begin
        byte_shift = {lane_i, 3'b000};
        half_shift = {lane_i[1], 4'b0000};
        byte_word  = word_i >> byte_shift;
        half_word  = word_i >> half_shift;
        byte_sel   = byte_word[7:0];
        half_sel   = half_word[15:0];
        byte_mask  = 32'h0000_00ff << byte_shift;
        half_mask  = 32'h0000_ffff << half_shift;

        load_data_o  = word_i;
        store_word_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o  = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                store_word_o = (word_i & ~byte_mask) | ({24'h0, wdata_i[7:0]} << byte_shift);
            end
            SZ_HALF: begin
                load_data_o  = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                store_word_o = (word_i & ~half_mask) | ({16'h0, wdata_i} << half_shift);
            end
            default: begin
                load_data_o  = word_i;
                store_word_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide little-endian memory with registered read data.
// Latency: word store 2, load 3, sub-word store 4 (RMW), fault 1 cycle from accept to resp.
// Backpressure: req_ready_o only in IDLE; response has no backpressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_fault_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] mem_data_i
);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;

    logic [31:0] load_data;
    logic [31:0] store_word;

    lsu_lane_align u_lane_align (
        .word_i       (mem_data_i),
        .lane_i       (req_q.lane),
        .size_i       (req_q.size),
        .unsigned_i   (req_q.is_unsigned),
        .wdata_i      (req_q.wdata),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_fault_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_d.write       = req_write_i;
                    req_d.size        = req_size_i;
                    req_d.is_unsigned = req_unsigned_i;
                    req_d.lane        = req_addr_i[1:0];
                    req_d.wdata       = req_wdata_i[15:0];
                    if (is_fault(req_size_i, req_addr_i, 32'(MEM_BYTES))) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        addr_d       = 32'h0;
                        data_d       = 32'h0;
                    end else if (req_write_i && (req_size_i == SZ_WORD)) begin
                        state_d     = ST_WR_ISSUE;
                        mem_write_d = 1'b1;
                        addr_d      = {req_addr_i[31:2], 2'b00};
                        data_d      = req_wdata_i;
                    end else begin
                        // Loads and sub-word stores both start with a word read.
                        state_d    = ST_RD_ISSUE;
                        mem_read_d = 1'b1;
                        addr_d     = {req_addr_i[31:2], 2'b00};
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = req_q.write ? ST_MERGE : ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                addr_d       = 32'h0;
            end
            ST_MERGE: begin
                state_d     = ST_WR_ISSUE;
                mem_write_d = 1'b1;
                data_d      = store_word;
            end
            ST_WR_ISSUE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                addr_d       = 32'h0;
                data_d       = 32'h0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= 32'h0;
            data_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_fault_o = resp_fault_q;
    assign MemRead_o    = mem_read_q;
    assign MemWrite_o   = mem_write_q;
    assign addr_o       = addr_q;
    assign data_o       = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read 32-byte memory model.
module tb_load_store_unit;

    logic        Clock_i = 1'b0;
    logic        Reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_fault_o;
    logic        MemWrite_o;
    logic        MemRead_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] mem_data_i;

    int checks   = 0;
    int failures = 0;

    always #5 Clock_i = ~Clock_i;

    load_store_unit #(.MEM_BYTES(32)) dut (
        .Clock_i        (Clock_i),
        .Reset_i        (Reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_fault_o   (resp_fault_o),
        .MemWrite_o     (MemWrite_o),
        .MemRead_o      (MemRead_o),
        .addr_o         (addr_o),
        .data_o         (data_o),
        .mem_data_i     (mem_data_i)
    );

    // Memory: write on strobe, read data registered one cycle after MemRead.
    logic [31:0] mem [0:7];
    always @(posedge Clock_i) begin
        if (MemWrite_o) mem[addr_o[4:2]] <= data_o;
        if (MemRead_o)  mem_data_i <= mem[addr_o[4:2]];
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
        int          nrd;
        int          nwr;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } vec_t;

    vec_t vecs[$];

    // Expected {ready, MemRead, resp_valid} per cycle of the busy sequence.
    logic [2:0] busy_pat [9] = '{3'b100, 3'b010, 3'b000, 3'b001, 3'b100,
                                 3'b010, 3'b000, 3'b001, 3'b100};

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic fault, input int cyc,
                                input int nrd, input int nwr, input logic [31:0] maddr,
                                input logic [31:0] mdata);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.fault = fault; v.cyc = cyc; v.nrd = nrd; v.nwr = nwr;
        v.maddr = maddr; v.mdata = mdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it the same way.
    task automatic run_req(input vec_t v, input string name);
        int          resp_cyc;
        int          nrd;
        int          nwr;
        int          both;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [31:0] rdata;
        logic        fault;
        resp_cyc = -1; nrd = 0; nwr = 0; both = 0;
        raddr = 32'h0; waddr = 32'h0; wdat = 32'h0; rdata = 32'h0; fault = 1'b0;
        req_valid_i = 1'b1; req_write_i = v.wr; req_size_i = v.sz;
        req_unsigned_i = v.uns; req_addr_i = v.addr; req_wdata_i = v.wdata;
        @(negedge Clock_i);
        check({name, "_ready"}, 32'(req_ready_o), 32'h1);
        @(posedge Clock_i); #1;
        req_valid_i = 1'b0;
        for (int c = 1; c <= 10 && resp_cyc < 0; c++) begin
            @(negedge Clock_i);
            if (MemRead_o)  begin nrd++; raddr = addr_o; end
            if (MemWrite_o) begin nwr++; waddr = addr_o; wdat = data_o; end
            if (MemRead_o && MemWrite_o) both++;
            if (resp_valid_o) begin
                resp_cyc = c; rdata = resp_rdata_o; fault = resp_fault_o;
            end
            @(posedge Clock_i); #1;
        end
        check({name, "_resp_cycle"}, 32'(resp_cyc), 32'(v.cyc));
        check({name, "_rdata"}, rdata, v.rdata);
        check({name, "_fault"}, 32'(fault), 32'(v.fault));
        check({name, "_reads"}, 32'(nrd), 32'(v.nrd));
        check({name, "_writes"}, 32'(nwr), 32'(v.nwr));
        check({name, "_both_strobes"}, 32'(both), 32'h0);
        if (v.nrd > 0) check({name, "_rd_addr"}, raddr, v.maddr);
        if (v.nwr > 0) begin
            check({name, "_wr_addr"}, waddr, v.maddr);
            check({name, "_wr_data"}, wdat, v.mdata);
        end
        @(negedge Clock_i);
        check({name, "_resp_cleared"}, {30'h0, resp_valid_o, resp_fault_o}, 32'h0);
        check({name, "_rdata_cleared"}, resp_rdata_o, 32'h0);
        @(posedge Clock_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;

        //      wr    sz     uns   addr    wdata         rdata         flt cyc rd wr maddr mdata
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'd8,  32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'd8,  32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'd9,  32'h0,        32'hFFFFFFBE, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'd9,  32'h0,        32'h000000BE, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'd10, 32'h0,        32'hFFFFDEAD, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'd10, 32'h0,        32'h0000DEAD, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'd11, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'd8,  32'h0,        32'hFFFFBEEF, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'd10, 32'hAAAAAA55, 32'h0,        1'b0, 4, 1, 1, 32'd8,  32'hDE55BEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'hDE55BEEF, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'd10, 32'hFFFF1234, 32'h0,        1'b0, 4, 1, 1, 32'd8,  32'h1234BEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'h1234BEEF, 1'b0, 3, 1, 0, 32'd8,  32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'd28, 32'hCAFEF00D, 32'h0,        1'b0, 2, 0, 1, 32'd28, 32'hCAFEF00D));
        vecs.push_back(mk(1'b1, 2'b00, 1'b1, 32'd31, 32'h00000080, 32'h0,        1'b0, 4, 1, 1, 32'd28, 32'h80FEF00D));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'd31, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0, 32'd28, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'd6,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd0,  32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'd3,  32'h1111,     32'h0,        1'b1, 1, 0, 0, 32'd0,  32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'd32, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd0,  32'h0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'd0,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd0,  32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'd32, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd0,  32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'd33, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'd0,  32'h0));

        repeat (3) @(posedge Clock_i);
        @(negedge Clock_i);
        check("reset_strobes", {30'h0, MemRead_o, MemWrite_o}, 32'h0);
        check("reset_addr", addr_o, 32'h0);
        check("reset_data", data_o, 32'h0);
        check("reset_resp", {30'h0, resp_valid_o, resp_fault_o}, 32'h0);
        check("reset_rdata", resp_rdata_o, 32'h0);
        check("reset_ready", 32'(req_ready_o), 32'h1);
        @(posedge Clock_i); #1;
        Reset_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i], $sformatf("v%0d", i));
        end

        // Busy: a changed request held during a load is taken only once back in IDLE.
        req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'b10;
        req_unsigned_i = 1'b0; req_addr_i = 32'd8; req_wdata_i = 32'h0;
        for (int c = 0; c < 9; c++) begin
            @(negedge Clock_i);
            check($sformatf("busy_c%0d_rdy_rd_resp", c),
                  {29'h0, req_ready_o, MemRead_o, resp_valid_o}, {29'h0, busy_pat[c]});
            if (c == 1) check("busy_addr1", addr_o, 32'd8);
            if (c == 5) check("busy_addr2", addr_o, 32'd28);
            if (c == 3) check("busy_rdata1", resp_rdata_o, 32'h1234BEEF);
            if (c == 7) check("busy_rdata2", resp_rdata_o, 32'h80FEF00D);
            @(posedge Clock_i); #1;
            if (c == 0) req_addr_i = 32'd28;
            if (c == 4) req_valid_i = 1'b0;
        end

        // Reset while in RD_CAPTURE aborts the load without a response.
        req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'd28;
        @(posedge Clock_i); #1;
        req_valid_i = 1'b0;
        @(negedge Clock_i);
        check("rst_mid_read_strobe", 32'(MemRead_o), 32'h1);
        @(posedge Clock_i); #1;
        Reset_i = 1'b1;
        @(negedge Clock_i);
        check("rst_mid_capture_no_resp", 32'(resp_valid_o), 32'h0);
        @(posedge Clock_i); #1;
        Reset_i = 1'b0;
        @(negedge Clock_i);
        check("rst_after_resp", {30'h0, resp_valid_o, resp_fault_o}, 32'h0);
        check("rst_after_rdata", resp_rdata_o, 32'h0);
        check("rst_after_strobes", {30'h0, MemRead_o, MemWrite_o}, 32'h0);
        check("rst_after_addr", addr_o, 32'h0);
        check("rst_after_data", data_o, 32'h0);
        check("rst_after_ready", 32'(req_ready_o), 32'h1);
        begin
            int late;
            late = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge Clock_i);
                if (resp_valid_o) late++;
            end
            check("rst_no_late_resp", 32'(late), 32'h0);
        end
        @(posedge Clock_i); #1;
        run_req(mk(1'b0, 2'b10, 1'b0, 32'd28, 32'h0, 32'h80FEF00D, 1'b0, 3, 1, 0, 32'd28, 32'h0),
                "post_rst_load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the 32-byte data memory. Takes byte, halfword and word load/store requests from the MEM pipeline stage and drives the memory's MemWrite/MemRead/addr/data port.
- Memory port is word-wide and little-endian: byte at addr+0 is bits [7:0]. Read data is registered, so it is valid the cycle after MemRead.
- The LSU always issues word-aligned addresses. It does lane extraction and sign extension for loads, and read-modify-write for sub-word stores.
- It flags misaligned and out-of-range accesses and never touches memory for them.

Parameters:
- MEM_BYTES, 32: memory size in bytes; multiple of 4. Byte addresses >= MEM_BYTES fault.

Ports:
- Clock_i  in  1  clock; all logic is on the rising edge.
- Reset_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  LSU can accept; high only in IDLE.
- req_write_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  loads only: zero-extend instead of sign-extend.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores and faults.
- resp_fault_o  out  1  misaligned, out-of-range or illegal size.
- MemWrite_o  out  1  memory write strobe.
- MemRead_o  out  1  memory read strobe.
- addr_o  out  32  word-aligned byte address; bits [1:0] always 00.
- data_o  out  32  memory write data.
- mem_data_i  in  32  memory read data.

Behaviour:
- Reset values:
  - state = IDLE.
  - MemWrite_o = MemRead_o = 0.
  - addr_o = data_o = 0.
  - resp_valid_o = 0, resp_rdata_o = 0, resp_fault_o = 0.
- States: IDLE, RD_ISSUE, RD_CAPTURE, MERGE, WR_ISSUE, RESP.
- Accept: in IDLE with req_valid_i = 1, latch the request (cycle 0). req_ready_o is 0 in every other state; requests presented there are ignored.
- Fault check at accept (all conditions):
  - size = 11.
  - size = half and addr[0] = 1.
  - size = word and addr[1:0] != 0.
  - req_addr_i >= MEM_BYTES.
  - On fault: go to RESP with resp_fault_o = 1. No memory strobe is issued.
- Load path: IDLE -> RD_ISSUE -> RD_CAPTURE -> RESP -> IDLE.
  - RD_ISSUE: MemRead_o = 1.
  - RD_CAPTURE: extract and extend mem_data_i, then register the result.
  - resp_valid_o is high in cycle 3.
- Word store path: IDLE -> WR_ISSUE -> RESP -> IDLE.
  - WR_ISSUE: MemWrite_o = 1, data_o = wdata.
  - resp_valid_o is high in cycle 2.
- Sub-word store path: IDLE -> RD_ISSUE -> MERGE -> WR_ISSUE -> RESP -> IDLE.
  - MERGE replaces only the addressed lane(s) of mem_data_i with wdata[7:0] or wdata[15:0].
  - resp_valid_o is high in cycle 4.
- Lane select:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Extension: sign-extend from bit 7 or 15 unless req_unsigned_i = 1. req_unsigned_i is ignored for word loads and for stores.
- Strobe rules:
  - MemWrite_o and MemRead_o are never high in the same cycle.
  - Each strobe is high for exactly one cycle per access.
  - addr_o holds the aligned address from RD_ISSUE through WR_ISSUE.
- RESP lasts one cycle. resp_* outputs are valid only while resp_valid_o = 1 and return to 0 afterwards. No back-pressure on the response.
- The next request can be accepted in the cycle after RESP (IDLE). Back-to-back word loads complete every 4 cycles.
- Reset mid-operation:
  - A strobe presented in the cycle Reset_i is high still reaches memory at that edge.
  - After the edge, the state is IDLE and all outputs are at reset values.
  - No resp_valid_o is emitted for the aborted request.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - state enumeration.
- Sub-module lsu_lane_align, combinational:
  - inputs: word, addr[1:0], size, unsigned, wdata.
  - outputs: extended load data, merged store word.
  - Shared by the RD_CAPTURE and MERGE states.

Test Plan:
- Word round-trip:
  - Store word 0xDEADBEEF at addr 8: MemWrite_o pulse in cycle 1 with addr_o = 8, resp_valid_o in cycle 2.
  - Then load word from 8: MemRead_o in cycle 1, resp_rdata_o = 0xDEADBEEF in cycle 3.
- Signed and unsigned byte loads, with memory word at 8 = 0xDEADBEEF:
  - signed byte at 9 -> 0xFFFFFFBE.
  - unsigned byte at 9 -> 0x000000BE.
  - signed half at 10 -> 0xFFFFDEAD.
- Sub-word RMW:
  - Store byte 0x55 at addr 10 over 0xDEADBEEF: exactly one read then one write.
  - data_o = 0xDE55BEEF; resp_valid_o in cycle 4.
  - Word reload returns 0xDE55BEEF.
- Faults, each with resp_fault_o = 1 in cycle 1, rdata = 0, and no MemRead_o/MemWrite_o pulse:
  - word load at 6.
  - half store at 3.
  - word load at 32.
  - size = 11.
- Busy and reset:
  - Hold req_valid_i = 1 during a load: req_ready_o = 0 until IDLE, and the second request is accepted only then.
  - Assert Reset_i in RD_CAPTURE: no resp_valid_o, outputs zero next cycle, and a fresh load completes normally.
